// File: rtl/traffic_pkg.sv
// traffic_pkg: lamp codes and phase encoding shared by the traffic controller
package traffic_pkg;
  localparam logic [2:0] LAMP_RED    = 3'b100;
  localparam logic [2:0] LAMP_GREEN  = 3'b010;
  localparam logic [2:0] LAMP_YELLOW = 3'b001;
  typedef enum logic [1:0] {
    PH_GREEN   = 2'b00,
    PH_YELLOW  = 2'b01,
    PH_ALL_RED = 2'b10
  } phase_e;
endpackage

// File: rtl/traffic_rr_arbiter.sv
// traffic_rr_arbiter: first requesting road after cur (wrapping, cur excluded), with found flag
module traffic_rr_arbiter #(
  parameter int NUM_ROADS = 2,
  localparam int RW = NUM_ROADS > 1 ? $clog2(NUM_ROADS) : 1
) (
  input  logic [NUM_ROADS-1:0] req,
  input  logic [RW-1:0]        cur,
  output logic [RW-1:0]        grant,
  output logic                 found
);
  logic [RW-1:0] j;
  always_comb begin
    grant = cur;
    found = 1'b0;
    j = '0;
    for (int i = NUM_ROADS - 1; i >= 1; i--) begin
      j = RW'((int'(cur) + i) % NUM_ROADS);
      if (req[j]) begin
        grant = j;
        found = 1'b1;
      end
    end
  end
endmodule

// File: rtl/traffic_phase_controller.sv
// traffic_phase_controller: N-road demand-actuated light sequencer with phase timer and all-red clearance
// Define TRAFFIC_PREEMPT_EN to add the preempt/preempt_road override inputs.
module traffic_phase_controller import traffic_pkg::*; #(
  parameter int NUM_ROADS     = 2,
  parameter int GREEN_CYCLES  = 10,
  parameter int YELLOW_CYCLES = 3,
  parameter int ALLRED_CYCLES = 1,
  parameter int CNT_W         = 8,
  localparam int RW = NUM_ROADS > 1 ? $clog2(NUM_ROADS) : 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NUM_ROADS-1:0]   req,
`ifdef TRAFFIC_PREEMPT_EN
  input  logic                   preempt,
  input  logic [RW-1:0]          preempt_road,
`endif
  output logic [3*NUM_ROADS-1:0] led_traffic,
  output logic [RW-1:0]          active_road,
  output logic [1:0]             phase,
  output logic [NUM_ROADS-1:0]   calls
);
  localparam logic [CNT_W-1:0] T_GREEN  = CNT_W'(GREEN_CYCLES - 1);
  localparam logic [CNT_W-1:0] T_YELLOW = CNT_W'(YELLOW_CYCLES - 1);
  localparam logic [CNT_W-1:0] T_ALLRED = CNT_W'(ALLRED_CYCLES - 1);

  phase_e                 phase_q, phase_d;
  logic [RW-1:0]          road_q, road_d, rr_grant, rr_road, road_inc, next_road;
  logic [CNT_W-1:0]       timer_q, timer_d;
  logic [NUM_ROADS-1:0]   calls_q, calls_d;
  logic                   rr_found, timer_zero, others, leave;

  traffic_rr_arbiter #(.NUM_ROADS(NUM_ROADS)) u_arb (
    .req   (calls_q),
    .cur   (road_q),
    .grant (rr_grant),
    .found (rr_found)
  );

  assign timer_zero = timer_q == '0;
  assign others     = |(calls_q & ~(NUM_ROADS'(1) << road_q));
  assign road_inc   = (road_q == RW'(NUM_ROADS - 1)) ? '0 : road_q + 1'b1;
  assign rr_road    = rr_found ? rr_grant : road_inc;
`ifdef TRAFFIC_PREEMPT_EN
  assign leave     = preempt ? (road_q != preempt_road) : (timer_zero && others);
  assign next_road = preempt ? preempt_road : rr_road;
`else
  assign leave     = timer_zero && others;
  assign next_road = rr_road;
`endif

  always_comb begin
    phase_d = phase_q;
    road_d  = road_q;
    timer_d = timer_zero ? '0 : timer_q - 1'b1;
    calls_d = calls_q | req;
    case (phase_q)
      PH_GREEN: if (leave) begin
        phase_d = PH_YELLOW;
        timer_d = T_YELLOW;
      end
      PH_YELLOW: if (timer_zero) begin
        phase_d = PH_ALL_RED;
        timer_d = T_ALLRED;
      end
      PH_ALL_RED: if (timer_zero) begin
        phase_d = PH_GREEN;
        timer_d = T_GREEN;
        road_d  = next_road;
        calls_d[next_road] = 1'b0;
      end
      default: begin
        phase_d = PH_ALL_RED;
        timer_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      phase_q <= PH_GREEN;
      road_q  <= '0;
      timer_q <= T_GREEN;
      calls_q <= '0;
    end else begin
      phase_q <= phase_d;
      road_q  <= road_d;
      timer_q <= timer_d;
      calls_q <= calls_d;
    end

  for (genvar k = 0; k < NUM_ROADS; k++) begin : g_lamp
    assign led_traffic[3*k +: 3] = (road_q != RW'(k)) ? LAMP_RED :
                                   (phase_q == PH_GREEN) ? LAMP_GREEN :
                                   (phase_q == PH_YELLOW) ? LAMP_YELLOW : LAMP_RED;
  end

  assign active_road = road_q;
  assign phase       = phase_q;
  assign calls       = calls_q;
endmodule
